// File: rtl/adder_cum_sub.sv
// Registered add/subtract slice built on a ripple-carry full-adder chain.
// cin selects the mode: 0 = i + j, 1 = i - j computed as i + ~j + 1.
// o and cout are registered; cout is the raw carry (1 = no borrow when subtracting).
module adder_cum_sub #(
  parameter int unsigned WIDTH = 4
) (
  output logic [WIDTH-1:0] o,
  output logic             cout,
  input  logic [WIDTH-1:0] i,
  input  logic [WIDTH-1:0] j,
  input  logic             cin,
  input  logic             clk,
  input  logic             rst
);

  logic [WIDTH-1:0] jb;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH:0]   carry;

  // Condition operand B for the selected mode, then ripple the carry through the chain.
  always_comb begin
    jb       = j ^ {WIDTH{cin}};
    sum_d    = '0;
    carry    = '0;
    carry[0] = cin;
    for (int k = 0; k < WIDTH; k++) begin
      sum_d[k]     = i[k] ^ jb[k] ^ carry[k];
      carry[k+1]   = (i[k] & jb[k]) | (carry[k] & (i[k] ^ jb[k]));
    end
  end

  // Result register; reset wins over the data load and discards the in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      o    <= '0;
      cout <= 1'b0;
    end else begin
      o    <= sum_d;
      cout <= carry[WIDTH];
    end
  end

endmodule

// File: tb/tb_adder_cum_sub.sv
// Self-checking bench for adder_cum_sub: directed plan, exhaustive sweep and random steps
// checked against an arithmetic reference model.
module tb_adder_cum_sub;

  localparam int unsigned W = 4;

  logic [W-1:0] o;
  logic         cout;
  logic [W-1:0] i;
  logic [W-1:0] j;
  logic         cin;
  logic         clk;
  logic         rst;

  int tests;
  int fails;

  adder_cum_sub #(
    .WIDTH(W)
  ) dut (
    .o   (o),
    .cout(cout),
    .i   (i),
    .j   (j),
    .cin (cin),
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain unsigned arithmetic, {carry, result}.
  function automatic logic [W:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sub, input logic r);
    int unsigned  ai;
    int unsigned  bi;
    int unsigned  res;
    logic [W:0]   out;
    ai = int'(a);
    bi = int'(b);
    if (r) begin
      out = '0;
    end else if (!sub) begin
      res = ai + bi;
      out[W-1:0] = res[W-1:0];
      out[W]     = (res >= (1 << W));
    end else begin
      res = (ai + (1 << W) - bi) % (1 << W);
      out[W-1:0] = res[W-1:0];
      out[W]     = (ai >= bi);
    end
    return out;
  endfunction

  task automatic check(input string tag, input logic [W:0] expected);
    logic [W:0] observed;
    observed = {cout, o};
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s: observed cout=%b o=%h, expected cout=%b o=%h",
             tag, observed[W], observed[W-1:0], expected[W], expected[W-1:0]);
    end
  endtask

  // Drive inputs just after an edge, clock once, land 1 time unit after the capture edge.
  task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                      input logic r);
    i   = a;
    j   = b;
    cin = c;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic step_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic c, input logic r);
    step(a, b, c, r);
    check(tag, ref_model(a, b, c, r));
  endtask

  initial begin
    logic [W:0] hold;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rr;
    tests = 0;
    fails = 0;
    i   = '0;
    j   = '0;
    cin = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset held two cycles with busy inputs, then the first post-reset result.
    step(4'hF, 4'hF, 1'b1, 1'b1);
    check("reset_c1", 5'h00);
    step(4'hF, 4'hF, 1'b1, 1'b1);
    check("reset_c2", 5'h00);
    step(4'hF, 4'hF, 1'b1, 1'b0);
    check("reset_release", 5'h10);

    // Add without carry.
    step(4'h0, 4'h0, 1'b0, 1'b0);
    check("add_0_0", 5'h00);
    step(4'h0, 4'h1, 1'b0, 1'b0);
    check("add_0_1", 5'h01);
    step(4'h0, 4'hC, 1'b0, 1'b0);
    check("add_0_c", 5'h0C);

    // Add with carry / wrap.
    step(4'hF, 4'hF, 1'b0, 1'b0);
    check("add_f_f", 5'h1E);
    step(4'h8, 4'h8, 1'b0, 1'b0);
    check("add_8_8", 5'h10);

    // Subtract without borrow.
    step(4'h0, 4'h0, 1'b1, 1'b0);
    check("sub_0_0", 5'h10);
    step(4'h1, 4'h0, 1'b1, 1'b0);
    check("sub_1_0", 5'h11);
    step(4'hF, 4'hF, 1'b1, 1'b0);
    check("sub_f_f", 5'h10);

    // Subtract with borrow.
    step(4'h0, 4'hC, 1'b1, 1'b0);
    check("sub_0_c", 5'h04);
    step(4'h3, 4'h5, 1'b1, 1'b0);
    check("sub_3_5", 5'h0E);

    // Output must not follow inputs between edges.
    hold = {cout, o};
    i   = 4'h7;
    j   = 4'h2;
    cin = 1'b0;
    #2;
    check("no_comb_path", hold);
    @(posedge clk);
    #1;
    check("after_comb_edge", 5'h09);

    // Mid-stream reset discards the in-flight result.
    step(4'hF, 4'hF, 1'b0, 1'b0);
    check("mid_load", 5'h1E);
    step(4'hF, 4'hF, 1'b0, 1'b1);
    check("mid_reset", 5'h00);

    // Exhaustive sweep of every operand/mode combination.
    for (int c = 0; c < 2; c++) begin
      for (int a = 0; a < (1 << W); a++) begin
        for (int b = 0; b < (1 << W); b++) begin
          step_check("sweep", W'(a), W'(b), c[0], 1'b0);
        end
      end
    end

    // Random steps with occasional reset pulses.
    for (int n = 0; n < 300; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      rr = ($urandom_range(0, 15) == 0);
      step_check("random", ra, rb, rc, rr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adder_cum_sub.md
Name: adder_cum_sub

Overview:
- Registered 4-bit adder/subtractor (parameterisable width) built on a ripple-carry full-adder chain.
- The cin input is the mode select:
  - cin=0 computes i + j.
  - cin=1 computes i − j in two's complement, as i + ~j + 1.
- Sum and carry are registered on the rising clock edge.
- Used as a small datapath ALU slice wherever a combined add/subtract with carry/borrow flag is needed.

Parameters:
- WIDTH, default 4: operand and result width in bits; must be ≥ 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- o  output  WIDTH  registered result (sum or difference), modulo 2^WIDTH.
- cout  output  1  registered carry-out of the MSB stage.
- i  input  WIDTH  operand A (minuend in subtract mode).
- j  input  WIDTH  operand B (subtrahend in subtract mode).
- cin  input  1  mode select and LSB carry-in: 0 = add, 1 = subtract.

Positional order of the core ports is o, cout, i, j, cin; clk and rst are connected by name.

Behaviour:
- Combinational datapath:
  - Operand B is conditioned as jb[k] = j[k] XOR cin for every bit k.
  - jb feeds a chain of WIDTH full adders, with stage-0 carry-in = cin.
  - Each stage computes s[k] = i[k] ^ jb[k] ^ c[k] and c[k+1] = (i[k]&jb[k]) | (c[k]&(i[k]^jb[k])).
  - Next-state result = s[WIDTH-1:0]; next-state carry = c[WIDTH].
- Add mode (cin=0):
  - o = (i + j) mod 2^WIDTH.
  - cout = 1 iff i + j ≥ 2^WIDTH (unsigned overflow).
- Subtract mode (cin=1):
  - o = (i − j) mod 2^WIDTH.
  - cout = 1 iff i ≥ j unsigned (no borrow); cout = 0 signals a borrow.
  - cout is the raw adder carry and is not inverted.
- Register stage:
  - On every rising clk edge with rst=0, o and cout load the next-state values.
  - Latency is 1 cycle: inputs applied before edge N appear on o/cout after edge N.
  - No enable; the outputs update on every cycle.
- Reset:
  - rst=1 at a rising edge forces o = 0 and cout = 0, regardless of the inputs.
  - Reset has priority over the data load.
  - Asserting rst mid-operation discards the in-flight result.
  - The first result after deassertion is the one captured at the first edge with rst=0.
- Before the first reset, output values are undefined; the bench must reset first.
- Boundary cases:
  - All-ones + all-ones in add mode wraps to all-ones−1 with cout=1.
  - x − x gives 0 with cout=1.
  - 0 − nonzero wraps, with cout=0.
- No signed-overflow flag is produced; signed interpretation is left to the consumer.
- Fully synchronous; no latches; no combinational path from inputs to outputs.

Test Plan:
- Reset: drive rst=1 for 2 cycles with i=F, j=F, cin=1 -> o=0, cout=0. Deassert rst; one cycle later o=0, cout=1.
- Add, no carry: (i,j,cin) = (0,0,0) -> o=0, cout=0; (0,1,0) -> o=1, cout=0; (0,C,0) -> o=C, cout=0. Each result appears one edge after it is applied.
- Add with carry/wrap: (F,F,0) -> o=E, cout=1; (8,8,0) -> o=0, cout=1.
- Subtract, no borrow: (0,0,1) -> o=0, cout=1; (1,0,1) -> o=1, cout=1; (F,F,1) -> o=0, cout=1.
- Subtract with borrow: (0,C,1) -> o=4, cout=0; (3,5,1) -> o=E, cout=0.
- Mid-stream reset and exhaustive check:
  - Apply (F,F,0), then assert rst on the following edge -> o=0, cout=0 that cycle.
  - Sweep all 512 combinations of i, j, cin and compare against the reference model {cout,o} = i + (j^{4{cin}}) + cin, delayed 1 cycle.
